// File: rtl/nibble_accumulator.sv
// Multi-operand nibble summing stage with sticky overflow.
// Operands in over valid/ready, one batch total out over valid/ready.
module nibble_accumulator #(
  parameter int NUM_OPS   = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_overflow,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [7:0]           op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;
  logic [7:0]           cnt;
  logic                 hs;
  logic                 last;
  logic [ACC_WIDTH:0]   sum_w;

  assign hs    = in_valid & (state == ACCUM);
  assign last  = (cnt == 8'(NUM_OPS - 1));
  assign sum_w = {1'b0, acc} + (ACC_WIDTH + 1)'(in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (hs) begin
            acc <= sum_w[ACC_WIDTH-1:0];
            ovf <= ovf | sum_w[ACC_WIDTH];
            cnt <= cnt + 8'd1;
            if (last)
              state <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here, even with out_ready
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state == ACCUM);
  assign out_valid    = (state == DONE);
  assign busy         = (state != IDLE);
  assign out_sum      = acc;
  assign out_overflow = ovf;
  assign op_count     = cnt;

endmodule

// File: tb/tb_nibble_accumulator.sv
// Scoreboard bench for nibble_accumulator.
// Two instances: a 4-operand unit and a 20-operand unit.
module tb_nibble_accumulator;

  typedef struct packed {
    logic [7:0] sum;
    logic       ovf;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [7:0] out_sum_a, op_count_a;
  logic       in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [7:0] out_sum_b, op_count_b;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  nibble_accumulator #(.NUM_OPS(4), .ACC_WIDTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_sum(out_sum_a), .out_overflow(out_ovf_a),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .busy(busy_a), .op_count(op_count_a)
  );

  nibble_accumulator #(.NUM_OPS(20), .ACC_WIDTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_sum(out_sum_b), .out_overflow(out_ovf_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .busy(busy_b), .op_count(op_count_b)
  );

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input int s, input int o, input int c);
    exp_t e;
    e.sum = 8'(s);
    e.ovf = 1'(o);
    e.cnt = 8'(c);
    return e;
  endfunction

  // Monitor: compare each accepted result against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_ready && out_valid_a) begin
      n_cmp++;
      if (sb_a.size() == 0) begin
        n_bad++;
        $display("FAIL mon_a: unexpected result sum=%0d", out_sum_a);
      end else begin
        e = sb_a.pop_front();
        if ({out_sum_a, out_ovf_a, op_count_a} != e) begin
          n_bad++;
          $display("FAIL mon_a: got sum=%0d ovf=%0d cnt=%0d expected sum=%0d ovf=%0d cnt=%0d",
                   out_sum_a, out_ovf_a, op_count_a, e.sum, e.ovf, e.cnt);
        end
      end
    end
    if (rst_n && out_ready && out_valid_b) begin
      n_cmp++;
      if (sb_b.size() == 0) begin
        n_bad++;
        $display("FAIL mon_b: unexpected result sum=%0d", out_sum_b);
      end else begin
        e = sb_b.pop_front();
        if ({out_sum_b, out_ovf_b, op_count_b} != e) begin
          n_bad++;
          $display("FAIL mon_b: got sum=%0d ovf=%0d cnt=%0d expected sum=%0d ovf=%0d cnt=%0d",
                   out_sum_b, out_ovf_b, op_count_b, e.sum, e.ovf, e.cnt);
        end
      end
    end
  end

  task automatic pulse(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input bit b, input logic [3:0] d);
    bit hs;
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      hs = b ? in_ready_b : in_ready_a;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 50);
    in_valid = 1'b0;
    if (!hs) check("send_timeout", 0, 1);
  endtask

  task automatic collect(input bit b);
    bit hs;
    int n;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      hs = b ? out_valid_b : out_valid_a;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 50);
    out_ready = 1'b0;
    if (!hs) check("collect_timeout", 0, 1);
  endtask

  initial begin
    logic [3:0] ops[4];
    int first_v;
    int edges;

    #1 rst_n = 1'b0;
    #1;
    check("rst_out_sum", out_sum_a, 0);
    check("rst_ovf", out_ovf_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_in_ready", in_ready_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_op_count", op_count_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic batch, back-to-back, latency measured from the start edge
    ops = '{4'd13, 4'd4, 4'd7, 4'd2};
    sb_a.push_back(mk(8'h1A, 0, 4));
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    edges = 1;
    first_v = 0;
    if (out_valid_a) first_v = edges;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = ops[i];
      @(posedge clk); #1;
      edges++;
      if (out_valid_a && first_v == 0) first_v = edges;
    end
    in_valid = 1'b0;
    check("basic_latency", first_v, 5);
    check("basic_busy", busy_a, 1);
    collect(0);

    // Overflow on the 20-operand unit, then cleared by the next start
    sb_b.push_back(mk(44, 1, 20));
    pulse(1);
    for (int i = 0; i < 20; i++) send(1, 4'd15);
    collect(1);
    sb_b.push_back(mk(4, 0, 20));
    pulse(1);
    for (int i = 0; i < 20; i++) send(1, (i < 4) ? 4'd1 : 4'd0);
    collect(1);

    // Gaps with start pulsed inside them, then backpressure
    ops = '{4'd9, 4'd15, 4'd15, 4'd9};
    sb_a.push_back(mk(48, 0, 4));
    pulse(0);
    for (int i = 0; i < 4; i++) begin
      send(0, ops[i]);
      check("gap_op_count", op_count_a, i + 1);
      if (i < 3) begin
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("gap_hold_count", op_count_a, i + 1);
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      start_a = (i == 0);
      @(posedge clk); #1;
      check("bp_out_valid", out_valid_a, 1);
      check("bp_out_sum", out_sum_a, 48);
      check("bp_in_ready", in_ready_a, 0);
      check("bp_op_count", op_count_a, 4);
    end
    start_a = 1'b0;
    collect(0);
    check("post_valid", out_valid_a, 0);

    // Operands offered in IDLE must be ignored
    in_data  = 4'hF;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_op_count", op_count_a, 4);
    check("idle_out_sum", out_sum_a, 48);
    check("idle_busy", busy_a, 0);

    // Asynchronous reset between edges after two operands
    pulse(0);
    send(0, 4'd5);
    send(0, 4'd6);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum", out_sum_a, 0);
    check("mid_rst_count", op_count_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_in_ready", in_ready_a, 0);
    check("mid_rst_valid", out_valid_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb_a.push_back(mk(10, 0, 4));
    pulse(0);
    for (int i = 1; i <= 4; i++) send(0, 4'(i));
    collect(0);

    // start together with out_ready in DONE: no new batch
    sb_a.push_back(mk(4, 0, 4));
    pulse(0);
    for (int i = 0; i < 4; i++) send(0, 4'd1);
    start_a   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start_a   = 1'b0;
    out_ready = 1'b0;
    check("simul_busy", busy_a, 0);
    check("simul_valid", out_valid_a, 0);
    sb_a.push_back(mk(14, 0, 4));
    pulse(0);
    check("restart_busy", busy_a, 1);
    for (int i = 2; i <= 5; i++) send(0, 4'(i));
    collect(0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
